// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: buffers clipped pixel plots in a small FIFO and drains them to frame-buffer RAM.
// Optional colour-key discard when TRANSPARENT_KEY_EN is defined.
module pixel_plot_sink #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17,
    parameter int COLOUR_W   = 6
`ifdef TRANSPARENT_KEY_EN
    , parameter logic [COLOUR_W-1:0] KEY_COLOUR = 6'b11_00_11
`endif
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                plotIn,
    input  logic [8:0]          xIn,
    input  logic [7:0]          yIn,
    input  logic [COLOUR_W-1:0] colourIn,
    input  logic                clearStatus,
`ifdef TRANSPARENT_KEY_EN
    input  logic                keyEnable,
`endif
    input  logic                memBusy,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [COLOUR_W-1:0] memData,
    output logic                fifoFull,
    output logic                overflow,
    output logic [7:0]          droppedCount
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, WRITE} stateT;
    stateT state, nextState;

    logic [PW-1:0]       rdPtr, wrPtr;
    logic [PW:0]         count, nextCount;
    logic [ADDR_W-1:0]   addrMem [FIFO_DEPTH];
    logic [COLOUR_W-1:0] colourMem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   pixAddr;
    logic                keyed, inRange, pop, push, lost, drop;

    generate
        if (H_RES == 320) begin : g_shift
            assign pixAddr = (ADDR_W'(yIn) << 8) + (ADDR_W'(yIn) << 6) + ADDR_W'(xIn);
        end else begin : g_mul
            assign pixAddr = ADDR_W'(yIn) * ADDR_W'(H_RES) + ADDR_W'(xIn);
        end
    endgenerate

`ifdef TRANSPARENT_KEY_EN
    assign keyed = keyEnable && colourIn == KEY_COLOUR;
`else
    assign keyed = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    always_comb begin
        inRange   = 32'(xIn) < H_RES && 32'(yIn) < V_RES;
        pop       = count != '0 && !memBusy;
        push      = plotIn && !keyed && inRange && (!fifoFull || pop);
        lost      = plotIn && !keyed && inRange && fifoFull && !pop;
        drop      = (plotIn && !keyed && !inRange) || lost;
        nextCount = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= IDLE;
        else         state <= nextState;

    always_comb nextState = pop ? WRITE : IDLE;

    always_comb memWe = state == WRITE;

    always_ff @(posedge Clock)
        if (push) begin
            addrMem[wrPtr]   <= pixAddr;
            colourMem[wrPtr] <= colourIn;
        end

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            fifoFull     <= 1'b0;
            memAddr      <= '0;
            memData      <= '0;
            overflow     <= 1'b0;
            droppedCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) begin
                rdPtr   <= rdPtr + PW'(1);
                memAddr <= addrMem[rdPtr];
                memData <= colourMem[rdPtr];
            end
            count    <= nextCount;
            fifoFull <= nextCount == (PW+1)'(FIFO_DEPTH);
            if (clearStatus) begin
                overflow     <= 1'b0;
                droppedCount <= '0;
            end else begin
                if (lost) overflow <= 1'b1;
                if (drop && droppedCount != 8'hFF) droppedCount <= droppedCount + 8'd1;
            end
        end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink: directed vector table plus multi-cycle sequences for pixel_plot_sink.
module tb_pixel_plot_sink;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        plotIn = 1'b0;
    logic [8:0]  xIn = '0;
    logic [7:0]  yIn = '0;
    logic [5:0]  colourIn = '0;
    logic        clearStatus = 1'b0;
    logic        keyEnable = 1'b0;
    logic        memBusy = 1'b0;
    logic        memWe;
    logic [16:0] memAddr;
    logic [5:0]  memData;
    logic        fifoFull, overflow;
    logic [7:0]  droppedCount;

    pixel_plot_sink dut (
        .Clock(Clock), .Resetn(Resetn), .plotIn(plotIn), .xIn(xIn), .yIn(yIn),
        .colourIn(colourIn), .clearStatus(clearStatus),
`ifdef TRANSPARENT_KEY_EN
        .keyEnable(keyEnable),
`endif
        .memBusy(memBusy), .memWe(memWe), .memAddr(memAddr), .memData(memData),
        .fifoFull(fifoFull), .overflow(overflow), .droppedCount(droppedCount)
    );

    always #5 Clock = ~Clock;

    int passed = 0, total = 0, cyc = 0;
    logic [22:0] wrQ[$];
    int wrCyc[$];
    logic fullSeen = 1'b0;

    always @(posedge Clock) cyc++;
    always @(negedge Clock) begin
        if (memWe) begin
            wrQ.push_back({memAddr, memData});
            wrCyc.push_back(cyc);
        end
        if (fifoFull) fullSeen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        plotIn = 1'b1; xIn = 9'(x); yIn = 8'(y); colourIn = 6'(c);
        tick();
        plotIn = 1'b0;
    endtask

    task automatic clearAll();
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        wrQ.delete();
        wrCyc.delete();
        fullSeen = 1'b0;
    endtask

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [5:0]  c;
        logic        we;
        logic [16:0] addr;
    } vecT;

    initial begin
        vecT vecs[7];
        int drops;
        int n;
        vecs[0] = '{9'd10,  8'd5,   6'h2A, 1'b1, 17'd1610};
        vecs[1] = '{9'd0,   8'd0,   6'h3F, 1'b1, 17'd0};
        vecs[2] = '{9'd319, 8'd239, 6'h01, 1'b1, 17'd76799};
        vecs[3] = '{9'd320, 8'd0,   6'h05, 1'b0, 17'd0};
        vecs[4] = '{9'd0,   8'd240, 6'h06, 1'b0, 17'd0};
        vecs[5] = '{9'd100, 8'd100, 6'h15, 1'b1, 17'd32100};
        vecs[6] = '{9'd511, 8'd255, 6'h07, 1'b0, 17'd0};

        tick();
        check("rst_memWe", 32'(memWe), 0);
        check("rst_memAddr", 32'(memAddr), 0);
        check("rst_memData", 32'(memData), 0);
        check("rst_fifoFull", 32'(fifoFull), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_dropped", 32'(droppedCount), 0);
        Resetn = 1'b1;
        tick();

        drops = 0;
        for (int i = 0; i < 7; i++) begin
            wrQ.delete();
            plot(int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].c));
            check($sformatf("v%0d_lat1", i), 32'(memWe), 0);
            tick();
            check($sformatf("v%0d_we", i), 32'(memWe), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("v%0d_addr", i), 32'(memAddr), 32'(vecs[i].addr));
                check($sformatf("v%0d_data", i), 32'(memData), 32'(vecs[i].c));
            end else drops++;
            tick();
            check($sformatf("v%0d_we_off", i), 32'(memWe), 0);
            check($sformatf("v%0d_nwrites", i), 32'(wrQ.size()), 32'(vecs[i].we));
            check($sformatf("v%0d_dropped", i), 32'(droppedCount), 32'(drops));
        end
        clearAll();
        check("clear_dropped", 32'(droppedCount), 0);

        // 8-pixel back-to-back burst
        for (int i = 0; i < 8; i++) begin
            plotIn = 1'b1; xIn = 9'(i * 3); yIn = 8'(i + 1); colourIn = 6'(i + 8);
            tick();
        end
        plotIn = 1'b0;
        repeat (4) tick();
        check("burst_n", 32'(wrQ.size()), 8);
        n = wrQ.size();
        for (int i = 0; i < 8 && i < n; i++)
            check($sformatf("burst_w%0d", i), 32'(wrQ[i]), 32'({17'((i + 1) * 320 + i * 3), 6'(i + 8)}));
        if (n == 8) check("burst_b2b", 32'(wrCyc[7] - wrCyc[0]), 7);
        check("burst_full", 32'(fullSeen), 0);
        check("burst_dropped", 32'(droppedCount), 0);

        // overflow under memBusy; address must hold while busy
        clearAll();
        memBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            plot(i + 1, 2, i + 16);
            if (i == 3) check("ovf_full", 32'(fifoFull), 1);
            if (i == 3) check("ovf_noflag_yet", 32'(overflow), 0);
        end
        check("busy_hold_addr", 32'(memAddr), 32'(8 * 320 + 21));
        check("busy_no_we", 32'(wrQ.size()), 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_dropped", 32'(droppedCount), 2);
        memBusy = 1'b0;
        repeat (7) tick();
        check("ovf_n", 32'(wrQ.size()), 4);
        n = wrQ.size();
        for (int i = 0; i < 4 && i < n; i++)
            check($sformatf("ovf_w%0d", i), 32'(wrQ[i]), 32'({17'(640 + i + 1), 6'(i + 16)}));
        check("ovf_full_drained", 32'(fifoFull), 0);

        // push and pop in the same cycle while full
        clearAll();
        memBusy = 1'b1;
        for (int i = 0; i < 4; i++) plot(i, 3, i + 32);
        check("pp_full", 32'(fifoFull), 1);
        memBusy = 1'b0;
        plot(4, 3, 36);
        repeat (7) tick();
        check("pp_n", 32'(wrQ.size()), 5);
        if (wrQ.size() == 5) check("pp_last", 32'(wrQ[4]), 32'({17'(964), 6'd36}));
        check("pp_overflow", 32'(overflow), 0);
        check("pp_dropped", 32'(droppedCount), 0);

        // saturation, then clear colliding with a drop
        clearAll();
        plotIn = 1'b1; xIn = 9'd400; yIn = 8'd0;
        repeat (300) tick();
        check("sat_dropped", 32'(droppedCount), 255);
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        check("clear_wins", 32'(droppedCount), 0);
        tick();
        plotIn = 1'b0;
        check("count_after_clear", 32'(droppedCount), 1);

        // reset in the middle of a queued burst
        clearAll();
        plot(320, 0, 0);
        memBusy = 1'b1;
        for (int i = 0; i < 3; i++) plot(i + 50, 7, i + 1);
        Resetn = 1'b0;
        #1;
        check("mid_rst_memAddr", 32'(memAddr), 0);
        check("mid_rst_dropped", 32'(droppedCount), 0);
        check("mid_rst_memWe", 32'(memWe), 0);
        check("mid_rst_fifoFull", 32'(fifoFull), 0);
        tick();
        Resetn = 1'b1;
        memBusy = 1'b0;
        repeat (6) tick();
        check("mid_rst_no_writes", 32'(wrQ.size()), 0);

`ifdef TRANSPARENT_KEY_EN
        clearAll();
        keyEnable = 1'b1;
        plot(1, 1, 6'h33);
        repeat (3) tick();
        check("key_no_write", 32'(wrQ.size()), 0);
        check("key_dropped", 32'(droppedCount), 0);
        keyEnable = 1'b0;
        plot(1, 1, 6'h33);
        repeat (3) tick();
        check("key_off_n", 32'(wrQ.size()), 1);
        if (wrQ.size() == 1) check("key_off_w", 32'(wrQ[0]), 32'({17'd321, 6'h33}));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
